// File: rtl/rs232out_fifo.sv
// Byte FIFO feeding the rs232out serializer with one-cycle write strobes whenever it is idle.
// Optional LF-to-CRLF expansion is enabled by defining RS232OUT_FIFO_CRLF_EN.
module rs232out_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_we,
  input  logic                  tx_busy,
  output logic                  dbg_crlf_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic                  r_tx_we;
  logic [7:0]            r_tx_data;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_pop;
  logic [7:0]            w_head;
  logic [7:0]            w_issue_data;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = wr_en & ~w_full;
  assign w_head  = r_mem[r_rd_ptr];

  // Handshake: tx_we is a single-cycle strobe carrying tx_data; the serializer raises
  // tx_busy the cycle after it samples tx_we, so the ~r_tx_we term blocks a second
  // strobe before busy becomes visible. A byte is consumed only when strobed.
  assign w_issue = ~w_empty & ~tx_busy & ~r_tx_we;

`ifdef RS232OUT_FIFO_CRLF_EN
  typedef enum logic {ST_IDLE, ST_CR_SENT} crlf_state_t;
  crlf_state_t r_state;
  crlf_state_t w_state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // An LF at the head is preceded by a CR that does not pop; the LF pops next time.
  always_comb begin
    w_state_next = r_state;
    w_pop        = w_issue;
    w_issue_data = w_head;
    if (w_issue) begin
      if (r_state == ST_IDLE) begin
        if (w_head == 8'h0A) begin
          w_pop        = 1'b0;
          w_issue_data = 8'h0D;
          w_state_next = ST_CR_SENT;
        end
      end else begin
        w_state_next = ST_IDLE;
      end
    end
  end

  assign dbg_crlf_state = (r_state == ST_CR_SENT);
`else
  assign w_pop          = w_issue;
  assign w_issue_data   = w_head;
  assign dbg_crlf_state = 1'b0;
`endif

  // Storage is not reset; only pointers and level define valid contents.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // A new overflow event wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_overflow <= 1'b0;
    else if (wr_en && w_full)  r_overflow <= 1'b1;
    else if (overflow_clr)     r_overflow <= 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_we   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_we <= w_issue;
      if (w_issue) r_tx_data <= w_issue_data;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign tx_we    = r_tx_we;
  assign tx_data  = r_tx_data;

endmodule
